// File: rtl/cmd_updown_counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_cmd_pkg
//
// Shared definitions for the command-driven up/down counter:
//   - command byte codes accepted from the UART RX FIFO
//   - the status-report state machine encoding
//   - ASCII line-feed terminator and the nibble-to-hex-ASCII helper
// ---------------------------------------------------------------------------
package counter_cmd_pkg;

    // Command bytes: ASCII 'r', 'c', 'm', 's'
    localparam logic [7:0] CMD_RUN    = 8'h72;
    localparam logic [7:0] CMD_CLEAR  = 8'h63;
    localparam logic [7:0] CMD_MODE   = 8'h6D;
    localparam logic [7:0] CMD_STATUS = 8'h73;

    // Terminator byte closing every status report
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    // Report engine states: waiting for 's', sending hex digits, sending LF
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        NL   = 2'd2
    } report_state_e;

    // Uppercase hex digit for one nibble: 0-9 -> '0'-'9', A-F -> 'A'-'F'
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        logic [7:0] wide;
        wide = {4'b0000, nib};
        if (nib < 4'd10) begin
            return 8'h30 + wide;
        end else begin
            return 8'h37 + wide;
        end
    endfunction

endpackage

// File: rtl/cmd_updown_counter_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
//
// Programmable step divider. While 'en' is high the internal divider walks
// 0..TICK_DIV-1; in the cycle it sits on the terminal value 'tick' is high
// and the divider returns to 0 on the next edge. 'clr' forces the divider
// back to 0 and suppresses the tick, taking precedence over 'en'.
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous reset, active low
//   en    in   count enable (counter is running)
//   clr   in   synchronous divider clear
//   tick  out  combinational step strobe, one cycle per TICK_DIV enabled cycles
// ---------------------------------------------------------------------------
module tick_gen #(
    parameter int TICK_DIV = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    // A divide-by-one needs no real divider bits, but keep one so the
    // register is never zero width; it then simply stays at 0.
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    // Next divider value and the step strobe. The clear wins over a pending
    // terminal count so a clear or a stop never produces a stray step.
    always_comb begin
        div_d = div_q;
        tick  = 1'b0;
        if (clr) begin
            div_d = '0;
        end else if (en) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                tick  = 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    // Divider register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/cmd_updown_counter.sv
// ---------------------------------------------------------------------------
// cmd_updown_counter
//
// Up/down counter with a programmable step divider and a wrap-or-saturate end
// policy. It is controlled by debounced button pulses and by command bytes
// from the UART RX FIFO ('r' run toggle, 'c' clear, 'm' mode toggle, 's'
// status), and answers 's' with the count as uppercase hex digits followed by
// a line feed on the TX byte stream.
//
// Parameters:
//   WIDTH      count register width
//   MAX_COUNT  terminal count value, below 2**WIDTH
//   TICK_DIV   clock cycles per count step, at least 1
//   WRAP       1 = wrap around at either end, 0 = saturate and stop
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous reset, active low
//   btn_clear  in   1-cycle pulse: clear count and divider
//   btn_run    in   1-cycle pulse: toggle run
//   btn_mode   in   1-cycle pulse: toggle up/down
//   cmd_data   in   RX FIFO byte
//   cmd_valid  in   RX byte valid
//   cmd_ready  out  byte consumed when cmd_valid & cmd_ready (report idle)
//   tx_data    out  report byte
//   tx_valid   out  report byte valid
//   tx_ready   in   TX FIFO can accept
//   count      out  current count
//   run        out  1 = counting
//   mode       out  0 = up, 1 = down
//   tick       out  1-cycle pulse on every count step
//   cmd_err    out  1-cycle pulse after an unknown byte is consumed
// ---------------------------------------------------------------------------
module cmd_updown_counter
    import counter_cmd_pkg::*;
#(
    parameter int WIDTH     = 14,
    parameter int MAX_COUNT = 9999,
    parameter int TICK_DIV  = 10_000_000,
    parameter int WRAP      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_clear,
    input  logic             btn_run,
    input  logic             btn_mode,
    input  logic [7:0]       cmd_data,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [WIDTH-1:0] count,
    output logic             run,
    output logic             mode,
    output logic             tick,
    output logic             cmd_err
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

    // Report geometry: one hex digit per started nibble of the count
    localparam int DIGITS = (WIDTH + 3) / 4;
    localparam int SNAP_W = DIGITS * 4;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // Counter state
    logic [WIDTH-1:0] count_q, count_d;
    logic             run_q, run_d;
    logic             mode_q, mode_d;
    logic             tick_q;
    logic             err_q;

    // Report engine state
    report_state_e    state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SNAP_W-1:0] snap_q, snap_d;

    // Decoded events for this cycle
    logic             accept;
    logic             isRun, isClear, isMode, isStatus;
    logic             clearEv, runEv, modeEv, unknownCmd;
    logic             divClr;
    logic             stepNow;
    logic [SNAP_W-1:0] snapShift;

    // The RX FIFO is only drained while no report is in flight, so 's'
    // requests and every other command simply wait in the FIFO meanwhile.
    assign cmd_ready = (state_q == IDLE);
    assign accept    = cmd_valid & cmd_ready;

    assign isRun     = (cmd_data == CMD_RUN);
    assign isClear   = (cmd_data == CMD_CLEAR);
    assign isMode    = (cmd_data == CMD_MODE);
    assign isStatus  = (cmd_data == CMD_STATUS);

    // A button and its matching command in the same cycle are ORed so that
    // they act as a single event (a run toggle from both sources toggles once).
    assign clearEv    = btn_clear | (accept & isClear);
    assign runEv      = btn_run   | (accept & isRun);
    assign modeEv     = btn_mode  | (accept & isMode);
    assign unknownCmd = accept & ~(isRun | isClear | isMode | isStatus);

    // Divider restarts on clear and when running stops through a toggle;
    // both also cancel any step that would have landed in this cycle.
    assign divClr = clearEv | (runEv & run_q);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (run_q),
        .clr  (divClr),
        .tick (stepNow)
    );

    // Count datapath. Clear, run toggle and mode toggle all take effect
    // together; a step uses the direction in force before any mode toggle,
    // so a direction change shows up on the following step. In saturate
    // mode reaching an end holds the count and stops the counter on the same
    // edge that would otherwise have stepped past it.
    always_comb begin
        count_d = count_q;
        run_d   = run_q ^ runEv;
        mode_d  = mode_q ^ modeEv;
        if (clearEv) begin
            count_d = '0;
        end else if (stepNow) begin
            if (!mode_q) begin
                if (count_q >= MAX_C) begin
                    if (WRAP != 0) begin
                        count_d = '0;
                    end else begin
                        count_d = MAX_C;
                        run_d   = 1'b0;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    if (WRAP != 0) begin
                        count_d = MAX_C;
                    end else begin
                        run_d   = 1'b0;
                    end
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    // Counter registers; tick and cmd_err are registered so they line up with
    // the count/state change they announce.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            run_q   <= 1'b0;
            mode_q  <= 1'b0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            run_q   <= run_d;
            mode_q  <= mode_d;
            tick_q  <= stepNow;
            err_q   <= unknownCmd;
        end
    end

    // Align the current digit at the top of the snapshot so the digit index
    // walks from the most significant nibble downwards.
    assign snapShift = snap_q << {idx_q, 2'b00};

    // Report engine: snapshot the count on 's', then hold each byte on
    // tx_data until the TX FIFO takes it, advancing straight to the next byte
    // so back-to-back transfers need no idle cycle. Outputs are decoded from
    // the registered state so a reset drops tx_valid immediately.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        snap_d   = snap_q;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state_q)
            IDLE: begin
                if (cmd_valid && isStatus) begin
                    snap_d  = SNAP_W'(count_q);
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = nibble_to_ascii(snapShift[SNAP_W-1 -: 4]);
                if (tx_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = NL;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            NL: begin
                tx_valid = 1'b1;
                tx_data  = ASCII_LF;
                if (tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Report engine registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
        end
    end

    assign count   = count_q;
    assign run     = run_q;
    assign mode    = mode_q;
    assign tick    = tick_q;
    assign cmd_err = err_q;

endmodule

// File: tb/tb_cmd_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_cmd_updown_counter
//
// Drives two counters side by side from the same buttons, command stream and
// tx_ready: instance A wraps with a 9999 terminal value, instance B saturates
// at 5. Both use a divide-by-4 step. A reference model built from the
// counter's rules predicts every output each cycle; directed scenarios are
// followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_cmd_updown_counter;

    localparam int TDIV = 4;
    localparam int MAXA = 9999;
    localparam int MAXB = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       btnClear, btnRun, btnMode;
    logic       cmdValid, txReady;
    logic [7:0] cmdData;

    logic        cmdReadyA, txValidA, runA, modeA, tickA, cmdErrA;
    logic [7:0]  txDataA;
    logic [13:0] countA;
    logic        cmdReadyB, txValidB, runB, modeB, tickB, cmdErrB;
    logic [7:0]  txDataB;
    logic [13:0] countB;

    always #5 clk = ~clk;

    cmd_updown_counter #(.WIDTH(14), .MAX_COUNT(MAXA), .TICK_DIV(TDIV), .WRAP(1)) dutA (
        .clk(clk), .rst(rst), .btn_clear(btnClear), .btn_run(btnRun), .btn_mode(btnMode),
        .cmd_data(cmdData), .cmd_valid(cmdValid), .cmd_ready(cmdReadyA),
        .tx_data(txDataA), .tx_valid(txValidA), .tx_ready(txReady),
        .count(countA), .run(runA), .mode(modeA), .tick(tickA), .cmd_err(cmdErrA));

    cmd_updown_counter #(.WIDTH(14), .MAX_COUNT(MAXB), .TICK_DIV(TDIV), .WRAP(0)) dutB (
        .clk(clk), .rst(rst), .btn_clear(btnClear), .btn_run(btnRun), .btn_mode(btnMode),
        .cmd_data(cmdData), .cmd_valid(cmdValid), .cmd_ready(cmdReadyB),
        .tx_data(txDataB), .tx_valid(txValidB), .tx_ready(txReady),
        .count(countB), .run(runB), .mode(modeB), .tick(tickB), .cmd_err(cmdErrB));

    int checks = 0;
    int errors = 0;

    // Reference model, index 0 = A, 1 = B
    int         mMax[2]  = '{MAXA, MAXB};
    bit         mWrap[2] = '{1'b1, 1'b0};
    int         mCnt[2];
    int         mDiv[2];
    bit         mRun[2], mMode[2], mTick[2], mErr[2];
    logic [7:0] mRepB[2][5];
    int         mRepLeft[2];
    string      HEX = "0123456789ABCDEF";

    logic [7:0] gotA[$];

    // One comparison: counts it, and on mismatch counts and reports it
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            mCnt[d] = 0; mDiv[d] = 0; mRun[d] = 0; mMode[d] = 0;
            mTick[d] = 0; mErr[d] = 0; mRepLeft[d] = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic modelEdge();
        bit busy, acc, clr, rt, mt, stopNow, stepped;
        if (!rst) begin
            modelReset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                busy = (mRepLeft[d] != 0);
                acc  = cmdValid && !busy;
                if (busy && txReady) mRepLeft[d]--;
                if (acc && cmdData == 8'h73) begin
                    for (int k = 0; k < 4; k++)
                        mRepB[d][k] = HEX[(mCnt[d] >> (12 - 4 * k)) % 16];
                    mRepB[d][4] = 8'h0A;
                    mRepLeft[d] = 5;
                end
                clr = btnClear || (acc && cmdData == 8'h63);
                rt  = btnRun   || (acc && cmdData == 8'h72);
                mt  = btnMode  || (acc && cmdData == 8'h6D);
                mErr[d] = acc && !(cmdData inside {8'h72, 8'h63, 8'h6D, 8'h73});
                stepped = 0;
                stopNow = 0;
                if (clr) begin
                    mCnt[d] = 0;
                    mDiv[d] = 0;
                end else if (mRun[d]) begin
                    if (rt) begin
                        mDiv[d] = 0;
                    end else begin
                        mDiv[d] = (mDiv[d] + 1) % TDIV;
                        stepped = (mDiv[d] == 0);
                    end
                end
                if (stepped) begin
                    if (!mMode[d]) begin
                        if (mCnt[d] < mMax[d]) mCnt[d] = mCnt[d] + 1;
                        else if (mWrap[d]) mCnt[d] = 0;
                        else stopNow = 1;
                    end else begin
                        if (mCnt[d] > 0) mCnt[d] = mCnt[d] - 1;
                        else if (mWrap[d]) mCnt[d] = mMax[d];
                        else stopNow = 1;
                    end
                end
                mTick[d] = stepped;
                mRun[d]  = (mRun[d] ^ rt) && !stopNow;
                mMode[d] = mMode[d] ^ mt;
            end
        end
    endtask

    task automatic checkOne(input int d, input string nm, input logic [13:0] c,
                            input logic r, input logic m, input logic t, input logic e,
                            input logic rdy, input logic v, input logic [7:0] dat);
        chk({nm, "_count"},     32'(c),   32'(mCnt[d]));
        chk({nm, "_run"},       32'(r),   32'(mRun[d]));
        chk({nm, "_mode"},      32'(m),   32'(mMode[d]));
        chk({nm, "_tick"},      32'(t),   32'(mTick[d]));
        chk({nm, "_cmd_err"},   32'(e),   32'(mErr[d]));
        chk({nm, "_cmd_ready"}, 32'(rdy), 32'(mRepLeft[d] == 0));
        chk({nm, "_tx_valid"},  32'(v),   32'(mRepLeft[d] != 0));
        if (mRepLeft[d] != 0)
            chk({nm, "_tx_data"}, 32'(dat), 32'(mRepB[d][5 - mRepLeft[d]]));
    endtask

    task automatic checkOutput();
        checkOne(0, "A", countA, runA, modeA, tickA, cmdErrA, cmdReadyA, txValidA, txDataA);
        checkOne(1, "B", countB, runB, modeB, tickB, cmdErrB, cmdReadyB, txValidB, txDataB);
    endtask

    // Drive one cycle of inputs (called at a negedge), clock it, then check
    task automatic applyStimulus(input logic bc, input logic br, input logic bm,
                                 input logic cv, input logic [7:0] cd, input logic tr);
        btnClear = bc; btnRun = br; btnMode = bm;
        cmdValid = cv; cmdData = cd; txReady = tr;
        #1;
        if (txValidA && txReady) gotA.push_back(txDataA);
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 8'h00, 1);
    endtask

    task automatic sendCmd(input logic [7:0] b);
        applyStimulus(0, 0, 0, 1, b, 1);
    endtask

    task automatic doReset();
        rst = 1'b0;
        modelReset();
        idle(2);
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0] expRep[5];
        logic [3:0] pat;
        int         base;
        logic [7:0] pendByte;
        bit         pend;
        logic [7:0] cmdTab[8];

        expRep = '{8'h32, 8'h37, 8'h30, 8'h46, 8'h0A};
        pat    = 4'b1001;
        cmdTab = '{8'h72, 8'h63, 8'h6D, 8'h73, 8'h72, 8'h41, 8'h00, 8'hFF};

        rst = 1'b0;
        btnClear = 0; btnRun = 0; btnMode = 0; cmdValid = 0; cmdData = 0; txReady = 0;
        modelReset();
        @(negedge clk);
        checkOutput();
        chk("reset_count", 32'(countA), 32'd0);
        chk("reset_cmd_ready", 32'(cmdReadyA), 32'd1);
        chk("reset_tx_data", 32'(txDataA), 32'd0);
        idle(1);
        rst = 1'b1;

        // Run for 40 cycles: A reaches 10, B saturates at 5 and stops
        sendCmd(8'h72);
        chk("s1_run_on", 32'(runA), 32'd1);
        idle(40);
        chk("s1_count10", 32'(countA), 32'd10);
        chk("s2_sat_hold", 32'(countB), 32'd5);
        chk("s2_sat_stop", 32'(runB), 32'd0);
        sendCmd(8'h72);
        idle(8);
        chk("s1_frozen", 32'(countA), 32'd10);
        chk("s1_run_off", 32'(runA), 32'd0);

        // Down from 0: A wraps to 9999, B holds 0 and stops
        doReset();
        sendCmd(8'h6D);
        sendCmd(8'h72);
        idle(4);
        chk("s3_down_wrap", 32'(countA), 32'd9999);
        chk("s3_mode", 32'(modeA), 32'd1);
        chk("s3_sat0_count", 32'(countB), 32'd0);
        chk("s3_sat0_stop", 32'(runB), 32'd0);
        sendCmd(8'h72);
        idle(2);

        // Status report of frozen 9999 with a stalling TX FIFO
        gotA.delete();
        sendCmd(8'h73);
        for (int i = 0; i < 30 && mRepLeft[0] != 0; i++)
            applyStimulus(0, 0, 0, 0, 8'h00, pat[3 - (i % 4)]);
        chk("s4_nbytes", 32'(gotA.size()), 32'd5);
        for (int k = 0; k < 5; k++)
            if (k < gotA.size()) chk($sformatf("s4_byte%0d", k), 32'(gotA[k]), 32'(expRep[k]));

        // Up past 9999 wraps to 0
        sendCmd(8'h6D);
        sendCmd(8'h72);
        idle(4);
        chk("s2_up_wrap", 32'(countA), 32'd0);
        idle(5);

        // Clear + run button + 'r' in one cycle: one toggle, count cleared
        applyStimulus(1, 1, 0, 1, 8'h72, 1);
        chk("s5_clear", 32'(countA), 32'd0);
        chk("s5_one_toggle", 32'(runA), 32'd0);
        sendCmd(8'h41);
        chk("s5_err_pulse", 32'(cmdErrA), 32'd1);
        idle(1);
        chk("s5_err_end", 32'(cmdErrA), 32'd0);
        chk("s5_run_kept", 32'(runA), 32'd0);

        // Reset in the middle of a report
        sendCmd(8'h72);
        idle(6);
        gotA.delete();
        sendCmd(8'h73);
        for (int i = 0; i < 20 && gotA.size() < 2; i++) idle(1);
        chk("s6_two_bytes", 32'(gotA.size()), 32'd2);
        rst = 1'b0;
        #1;
        chk("s6_async_txv_A", 32'(txValidA), 32'd0);
        chk("s6_async_txv_B", 32'(txValidB), 32'd0);
        modelReset();
        @(negedge clk);
        idle(2);
        rst = 1'b1;
        base = gotA.size();
        idle(6);
        chk("s6_no_more_tx", 32'(gotA.size()), 32'(base));
        chk("s6_ready", 32'(cmdReadyA), 32'd1);
        chk("s6_count", 32'(countA), 32'd0);

        // Randomized traffic
        pend = 0;
        pendByte = 8'h00;
        for (int i = 0; i < 1500; i++) begin
            if (!pend && $urandom_range(0, 3) == 0) begin
                pend = 1;
                pendByte = cmdTab[$urandom_range(0, 7)];
            end
            base = mRepLeft[0];
            applyStimulus($urandom_range(0, 40) == 0, $urandom_range(0, 25) == 0,
                          $urandom_range(0, 30) == 0, pend, pendByte, 1'($urandom_range(0, 1)));
            if (pend && base == 0) pend = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
